mem8_word_sequencer: RTL and testbench
======================================

// Module: mem8_word_sequencer
// PURPOSE
//  Sequences byte/half/word load-store requests onto the single-port 8-bit data memory.
//  Memory: 256 x 8; combinational read under MemRead; write on posedge when MemWrite.
//  Splits each request into 1/2/4 byte beats, little-endian.
//  Assembles and optionally sign-extends read data.
//  Sits between the CPU load/store unit (valid/ready) and the memory.
// PARAMETERS
//  ADDR_W      8   byte address width; memory depth = 2**ADDR_W
//  WORD_BYTES  4   max bytes per request; RspRData width = 8*WORD_BYTES
// PORTS
//  Clk          in   1   sole clock, rising edge
//  Rst          in   1   asynchronous reset, active-high
//  ReqValid     in   1   request present
//  ReqReady     out  1   sequencer accepts request this cycle
//  ReqWrite     in   1   1=store, 0=load
//  ReqSize      in   2   00=byte, 01=half, 10=word, 11=illegal
//  ReqSigned    in   1   sign-extend load result
//  ReqAddr      in   8   byte address
//  ReqWData     in   32  store data, byte 0 = bits[7:0]
//  RspValid     out  1   response present
//  RspReady     in   1   consumer takes response
//  RspRData     out  32  load result (0 for stores and errors)
//  RspErr       out  1   misaligned or illegal size; no memory access made
//  MemAddr      out  8   to memory Address
//  MemWriteData out  8   to memory WriteData
//  MemWrite     out  1   to memory MemWrite
//  MemRead      out  1   to memory MemRead
//  MemReadData  in   8   from memory ReadData
// BEHAVIOUR
//  Reset values: state IDLE; RspValid=0, RspErr=0, RspRData=0, MemWrite=0, MemRead=0,
//   MemAddr=0, MemWriteData=0. ReqReady=0 while Rst is high.
//  FSM: IDLE -> ACCESS | RESP; ACCESS -> RESP; RESP -> IDLE.
//  IDLE: ReqReady=1. Fire on ReqValid&ReqReady; latch addr, size, write, signed, wdata.
//   Error cases go straight to RESP with RspErr=1:
//   - ReqSize=11
//   - half with ReqAddr[0]=1
//   - word with ReqAddr[1:0]!=0
//   Otherwise go to ACCESS with beat=0 and last=bytes-1.
//  ACCESS: one beat per cycle.
//   MemAddr = base+beat; no wrap is possible because accesses are aligned.
//   Store: MemWrite=1, MemRead=0, MemWriteData = wdata[8*beat+:8].
//   Load: MemRead=1, MemWrite=0; capture MemReadData into rdata[8*beat+:8] at the edge.
//   beat==last -> RESP at that edge; else beat+1.
//  RESP: RspValid=1, held stable until RspReady. Then go to IDLE, RspValid=0.
//   A new request is accepted no earlier than the cycle after the response handshake.
//  Load result:
//   - unsigned: zero-fill above the access size
//   - signed: replicate bit 7 (byte) or bit 15 (half)
//   Store result: RspRData=0.
//  Latency, accept edge to RspValid high: 1/2/4 cycles for byte/half/word; 0 cycles for errors.
//  MemWrite and MemRead are never high together; both are 0 outside ACCESS.
//  Reset mid-ACCESS: asynchronous return to IDLE and memory strobes drop immediately.
//   Bytes already written stay written; no response is issued.
//  RspReady asserted while RspValid=0 is ignored. ReqValid while not ready is ignored
//   (requester holds it).
// STRUCTURE
//  Shared package mem8_pkg: SIZE_BYTE/HALF/WORD/ILL codes; FSM state encoding
//   (IDLE, ACCESS, RESP); function size_to_last(size).
//  One natural sub-module: mem8_load_extend, combinational.
//   Inputs: rdata[31:0], size, signed. Output: extended 32-bit result.
//  Beat counter is 2 bits; the capture register is 32 bits.
// TESTING (bench instantiates MultiMem8-style 256x8 model, preloaded)
//  1 Word store 0xA1B2C3D4 @0x10 -> 4 write beats at 0x10..0x13 carrying D4,C3,B2,A1;
//    RspValid on 4th edge, RspErr=0.
//  2 Word load @0x10 after (1) -> RspRData=0xA1B2C3D4;
//    MemRead high for exactly 4 cycles, MemWrite stays 0.
//  3 Byte load @0x13, signed -> 0xFFFFFFA1; unsigned -> 0x000000A1;
//    half load @0x12 signed -> 0xFFFFA1B2.
//  4 Half @0x11 and word @0x0E -> RspErr=1, RspRData=0, no MemRead/MemWrite pulse,
//    memory unchanged.
//  5 Hold RspReady=0 for 5 cycles -> RspValid/RspRData stable, ReqReady=0;
//    back-to-back request accepted the cycle after the handshake.
//  6 Assert Rst after 2nd beat of word store @0x20 -> strobes drop at once, state IDLE;
//    0x20,0x21 updated, 0x22,0x23 unchanged; no RspValid.

Source files
------------

// File: rtl/mem8_pkg.sv
// Shared definitions for the 8-bit memory word sequencer: access size codes, FSM encoding
// and request decode helpers.
package mem8_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_ILL  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StAccess = 2'b01,
    StResp   = 2'b10
  } state_e;

  // Index of the final beat for a legal size.
  function automatic logic [1:0] size_to_last(size_e size);
    case (size)
      SIZE_HALF: return 2'd1;
      SIZE_WORD: return 2'd3;
      default:   return 2'd0;
    endcase
  endfunction

  // Requests rejected without touching memory: illegal size or misaligned address.
  function automatic logic req_is_error(size_e size, logic [1:0] addr_lo);
    case (size)
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return addr_lo[0];
      SIZE_WORD: return addr_lo != 2'b00;
      default:   return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem8_word_sequencer_if.sv
// Load/store request, response and byte-memory signals of the word sequencer.
// slave = sequencer side, master = load/store unit plus memory side.
interface mem8_word_sequencer_if #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned WORD_BYTES = 4
);
  logic                    ReqValid;
  logic                    ReqReady;
  logic                    ReqWrite;
  logic [1:0]              ReqSize;
  logic                    ReqSigned;
  logic [ADDR_W-1:0]       ReqAddr;
  logic [8*WORD_BYTES-1:0] ReqWData;

  logic                    RspValid;
  logic                    RspReady;
  logic [8*WORD_BYTES-1:0] RspRData;
  logic                    RspErr;

  logic [ADDR_W-1:0]       MemAddr;
  logic [7:0]              MemWriteData;
  logic                    MemWrite;
  logic                    MemRead;
  logic [7:0]              MemReadData;

  modport slave (
    input  ReqValid, ReqWrite, ReqSize, ReqSigned, ReqAddr, ReqWData, RspReady, MemReadData,
    output ReqReady, RspValid, RspRData, RspErr, MemAddr, MemWriteData, MemWrite, MemRead
  );

  modport master (
    output ReqValid, ReqWrite, ReqSize, ReqSigned, ReqAddr, ReqWData, RspReady, MemReadData,
    input  ReqReady, RspValid, RspRData, RspErr, MemAddr, MemWriteData, MemWrite, MemRead
  );
endinterface

// File: rtl/mem8_load_extend.sv
// Combinational load-result formatter: zero- or sign-extends byte and half loads to 32 bits.
module mem8_load_extend
  import mem8_pkg::*;
(
  input  logic [31:0] rdata,
  input  size_e       size,
  input  logic        sext,
  output logic [31:0] result
);

  always_comb begin
    result = rdata;
    case (size)
      SIZE_BYTE: result = {{24{sext & rdata[7]}}, rdata[7:0]};
      SIZE_HALF: result = {{16{sext & rdata[15]}}, rdata[15:0]};
      default:   result = rdata;
    endcase
  end

endmodule

// File: rtl/mem8_word_sequencer.sv
// Splits byte/half/word load-store requests into little-endian byte beats on a single-port
// 256x8 memory and returns an assembled, optionally sign-extended response.
module mem8_word_sequencer
  import mem8_pkg::*;
#(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned WORD_BYTES = 4
) (
  input  logic                  Clk,
  input  logic                  Rst,
  mem8_word_sequencer_if.slave  bus
);

  localparam int unsigned DataW = 8 * WORD_BYTES;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  size_e             size_q;
  logic              write_q;
  logic              sext_q;
  logic              err_q;
  logic [DataW-1:0]  wdata_q;
  logic [DataW-1:0]  rdata_q;
  logic [1:0]        beat_q;
  logic [1:0]        last_q;

  logic              req_ready;
  logic              fire;
  logic              req_err;
  size_e             req_size;
  logic [31:0]       load_result;

  assign req_size  = size_e'(bus.ReqSize);
  assign req_err   = req_is_error(req_size, bus.ReqAddr[1:0]);
  // Ready is gated by Rst directly so nothing is accepted while reset is held.
  assign req_ready = (state_q == StIdle) && !Rst;
  assign fire      = bus.ReqValid && req_ready;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (fire) state_d = req_err ? StResp : StAccess;
      end
      StAccess: begin
        if (beat_q == last_q) state_d = StResp;
      end
      StResp: begin
        if (bus.RspReady) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      addr_q  <= '0;
      size_q  <= SIZE_BYTE;
      write_q <= 1'b0;
      sext_q  <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      beat_q  <= '0;
      last_q  <= '0;
    end else if (fire) begin
      addr_q  <= bus.ReqAddr;
      size_q  <= req_size;
      write_q <= bus.ReqWrite;
      sext_q  <= bus.ReqSigned;
      err_q   <= req_err;
      wdata_q <= bus.ReqWData;
      rdata_q <= '0;
      beat_q  <= '0;
      last_q  <= size_to_last(req_size);
    end else if (state_q == StAccess) begin
      if (!write_q) rdata_q[8*beat_q +: 8] <= bus.MemReadData;
      beat_q <= beat_q + 2'd1;
    end
  end

  mem8_load_extend u_load_extend (
    .rdata  (rdata_q[31:0]),
    .size   (size_q),
    .sext   (sext_q),
    .result (load_result)
  );

  always_comb begin
    bus.ReqReady     = req_ready;
    bus.RspValid     = 1'b0;
    bus.RspErr       = 1'b0;
    bus.RspRData     = '0;
    bus.MemAddr      = '0;
    bus.MemWriteData = '0;
    bus.MemWrite     = 1'b0;
    bus.MemRead      = 1'b0;
    case (state_q)
      StAccess: begin
        // Aligned accesses never carry out of the low address bits, so no wrap handling.
        bus.MemAddr      = addr_q + ADDR_W'(beat_q);
        bus.MemWriteData = wdata_q[8*beat_q +: 8];
        bus.MemWrite     = write_q;
        bus.MemRead      = !write_q;
      end
      StResp: begin
        bus.RspValid = 1'b1;
        bus.RspErr   = err_q;
        bus.RspRData = (err_q || write_q) ? '0 : DataW'(load_result);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem8_word_sequencer.sv
// Self-checking bench for mem8_word_sequencer: 256x8 memory model, reference byte array and
// an expected-response queue filled at request acceptance.
module tb_mem8_word_sequencer;
  import mem8_pkg::*;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  always #5 Clk = ~Clk;

  mem8_word_sequencer_if bif ();

  mem8_word_sequencer dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bif)
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  rsp_t        exp_q[$];
  logic [7:0]  sim_mem[256];
  logic [7:0]  ref_mem[256];
  bit          loaded;
  int          n_vec, n_err;
  int          rd_cycles, wr_cycles, both_hi;
  logic [15:0] wr_log[$];

  function automatic logic [7:0] init_byte(int i);
    return 8'((i * 37 + 11) & 255);
  endfunction

  // Memory model: preloaded on the first edge, written on posedge when MemWrite.
  always @(posedge Clk) begin
    if (!loaded) begin
      for (int i = 0; i < 256; i++) sim_mem[i] <= init_byte(i);
      loaded <= 1'b1;
    end else if (bif.MemWrite) begin
      sim_mem[bif.MemAddr] <= bif.MemWriteData;
    end
    if (bif.MemWrite) begin
      wr_cycles++;
      wr_log.push_back({bif.MemAddr, bif.MemWriteData});
    end
    if (bif.MemRead) rd_cycles++;
    if (bif.MemWrite && bif.MemRead) both_hi++;
  end

  assign bif.MemReadData = bif.MemRead ? sim_mem[bif.MemAddr] : 8'h00;

  // Reference behaviour: updates ref_mem for stores and computes the expected response.
  task automatic model(input bit wr, input logic [1:0] sz, input bit sg, input logic [7:0] a,
                       input logic [31:0] wd, output rsp_t r);
    int nb;
    logic [31:0] v;
    r.err   = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
    r.rdata = 32'h0;
    if (!r.err) begin
      nb = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
      v  = 32'h0;
      for (int i = 0; i < nb; i++) begin
        if (wr) ref_mem[a + 8'(i)] = wd[8*i +: 8];
        else    v = v | (32'(ref_mem[a + 8'(i)]) << (8 * i));
      end
      if (!wr) begin
        if (sg && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
        r.rdata = v;
      end
    end
  endtask

  // Presents a request, waits (bounded) for acceptance; returns #1 after the accept edge.
  task automatic issue(input bit wr, input logic [1:0] sz, input bit sg, input logic [7:0] a,
                       input logic [31:0] wd, input bit track);
    bit   ok;
    rsp_t r;
    @(negedge Clk);
    bif.ReqValid  = 1'b1;
    bif.ReqWrite  = wr;
    bif.ReqSize   = sz;
    bif.ReqSigned = sg;
    bif.ReqAddr   = a;
    bif.ReqWData  = wd;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (bif.ReqReady) begin
        ok = 1'b1;
        break;
      end
      @(negedge Clk);
    end
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout: ReqReady=%b required 1", bif.ReqReady);
    end
    if (track) begin
      model(wr, sz, sg, a, wd, r);
      exp_q.push_back(r);
    end
    @(posedge Clk);
    #1;
    bif.ReqValid = 1'b0;
  endtask

  // Waits (bounded) for the response, records it, completes the handshake.
  task automatic collect(output logic [31:0] rd, output logic er, output int lat);
    lat = 0;
    bif.RspReady = 1'b1;
    while (!bif.RspValid && lat < 20) begin
      @(posedge Clk);
      #1;
      lat++;
    end
    if (!bif.RspValid) begin
      n_vec++;
      n_err++;
      $display("FAIL rsp_timeout: RspValid=%b required 1", bif.RspValid);
    end
    rd = bif.RspRData;
    er = bif.RspErr;
    @(posedge Clk);
    #1;
    bif.RspReady = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_vec++;
    if (bif.ReqReady !== 1'b0) begin
      n_err++; $display("FAIL reset_ready: got %b required 0", bif.ReqReady);
    end
    n_vec++;
    if ({bif.RspValid, bif.RspErr, bif.MemWrite, bif.MemRead} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_flags: got %b required 0000",
               {bif.RspValid, bif.RspErr, bif.MemWrite, bif.MemRead});
    end
    n_vec++;
    if ({bif.RspRData, bif.MemAddr, bif.MemWriteData} !== 48'h0) begin
      n_err++;
      $display("FAIL reset_data: got %h required 0",
               {bif.RspRData, bif.MemAddr, bif.MemWriteData});
    end
    @(negedge Clk);
    @(negedge Clk);
    Rst = 1'b0;
    #1;
    n_vec++;
    if (bif.ReqReady !== 1'b1) begin
      n_err++; $display("FAIL idle_ready: got %b required 1", bif.ReqReady);
    end
  endtask

  task automatic test_word_store();
    logic [31:0] rd;
    logic        er;
    int          lat, r0, w0, l0;
    rsp_t        e;
    logic [7:0]  bytes[4];
    bytes = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
    r0 = rd_cycles; w0 = wr_cycles; l0 = wr_log.size();
    issue(1'b1, 2'b10, 1'b0, 8'h10, 32'hA1B2_C3D4, 1'b1);
    collect(rd, er, lat);
    e = exp_q.pop_front();
    n_vec++;
    if ({rd, er} !== {e.rdata, e.err}) begin
      n_err++; $display("FAIL st_word_rsp: got %h/%b required %h/%b", rd, er, e.rdata, e.err);
    end
    n_vec++;
    if (lat !== 4) begin
      n_err++; $display("FAIL st_word_latency: got %0d required 4", lat);
    end
    n_vec++;
    if (wr_cycles - w0 !== 4 || rd_cycles - r0 !== 0) begin
      n_err++;
      $display("FAIL st_word_strobes: wr=%0d rd=%0d required 4/0", wr_cycles - w0,
               rd_cycles - r0);
    end
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (l0 + i >= wr_log.size()) begin
        n_err++; $display("FAIL st_word_beat%0d: missing write beat", i);
      end else if (wr_log[l0+i] !== {8'h10 + 8'(i), bytes[i]}) begin
        n_err++;
        $display("FAIL st_word_beat%0d: got %h required %h", i, wr_log[l0+i],
                 {8'h10 + 8'(i), bytes[i]});
      end
    end
  endtask

  task automatic test_word_load();
    logic [31:0] rd;
    logic        er;
    int          lat, r0, w0;
    rsp_t        e;
    r0 = rd_cycles; w0 = wr_cycles;
    issue(1'b0, 2'b10, 1'b0, 8'h10, 32'h0, 1'b1);
    collect(rd, er, lat);
    e = exp_q.pop_front();
    n_vec++;
    if (rd !== e.rdata || rd !== 32'hA1B2_C3D4 || er !== 1'b0) begin
      n_err++; $display("FAIL ld_word_data: got %h/%b required a1b2c3d4/0", rd, er);
    end
    n_vec++;
    if (rd_cycles - r0 !== 4 || wr_cycles - w0 !== 0 || lat !== 4) begin
      n_err++;
      $display("FAIL ld_word_strobes: rd=%0d wr=%0d lat=%0d required 4/0/4", rd_cycles - r0,
               wr_cycles - w0, lat);
    end
  endtask

  task automatic test_byte_half_load();
    logic [31:0] rd;
    logic        er;
    int          lat;
    rsp_t        e;
    logic [7:0]  addr[4];
    logic [1:0]  size[4];
    bit          sgn[4];
    logic [31:0] want[4];
    int          want_lat[4];
    addr = '{8'h13, 8'h13, 8'h12, 8'h12};
    size = '{2'b00, 2'b00, 2'b01, 2'b01};
    sgn  = '{1'b1, 1'b0, 1'b1, 1'b0};
    want = '{32'hFFFF_FFA1, 32'h0000_00A1, 32'hFFFF_A1B2, 32'h0000_A1B2};
    want_lat = '{1, 1, 2, 2};
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, size[i], sgn[i], addr[i], 32'h0, 1'b1);
      collect(rd, er, lat);
      e = exp_q.pop_front();
      n_vec++;
      if (rd !== e.rdata || rd !== want[i] || er !== 1'b0) begin
        n_err++; $display("FAIL ld_small%0d: got %h/%b required %h/0", i, rd, er, want[i]);
      end
      n_vec++;
      if (lat !== want_lat[i]) begin
        n_err++; $display("FAIL ld_small%0d_lat: got %0d required %0d", i, lat, want_lat[i]);
      end
    end
  endtask

  task automatic test_misaligned();
    logic [31:0] rd;
    logic        er;
    int          lat, r0, w0, bad;
    rsp_t        e;
    logic [7:0]  addr[4];
    logic [1:0]  size[4];
    bit          wr[4];
    addr = '{8'h11, 8'h0E, 8'h00, 8'h02};
    size = '{2'b01, 2'b10, 2'b11, 2'b10};
    wr   = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      r0 = rd_cycles; w0 = wr_cycles;
      issue(wr[i], size[i], 1'b1, addr[i], 32'hDEAD_BEEF, 1'b1);
      collect(rd, er, lat);
      e = exp_q.pop_front();
      n_vec++;
      if ({rd, er} !== {e.rdata, e.err} || {rd, er} !== {32'h0, 1'b1} || lat !== 0) begin
        n_err++;
        $display("FAIL err_case%0d: got %h/%b lat %0d required 0/1 lat 0", i, rd, er, lat);
      end
      n_vec++;
      if (rd_cycles != r0 || wr_cycles != w0) begin
        n_err++;
        $display("FAIL err_case%0d_strobes: rd=%0d wr=%0d required 0/0", i, rd_cycles - r0,
                 wr_cycles - w0);
      end
    end
    bad = 0;
    for (int i = 0; i < 256; i++) if (sim_mem[i] !== ref_mem[i]) bad++;
    n_vec++;
    if (bad != 0) begin
      n_err++; $display("FAIL mem_unchanged: got %0d differing bytes required 0", bad);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    logic        er;
    int          lat, k;
    rsp_t        e, r;
    bif.RspReady = 1'b0;
    issue(1'b0, 2'b00, 1'b0, 8'h10, 32'h0, 1'b1);
    k = 0;
    while (!bif.RspValid && k < 20) begin
      @(posedge Clk);
      #1;
      k++;
    end
    e = exp_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      n_vec++;
      if ({bif.RspValid, bif.ReqReady, bif.RspRData} !== {2'b10, e.rdata}) begin
        n_err++;
        $display("FAIL hold%0d: valid/ready/data got %b/%b/%h required 1/0/%h", i,
                 bif.RspValid, bif.ReqReady, bif.RspRData, e.rdata);
      end
    end
    // Release the response and present the next request in the same cycle.
    bif.RspReady  = 1'b1;
    bif.ReqValid  = 1'b1;
    bif.ReqWrite  = 1'b0;
    bif.ReqSize   = 2'b01;
    bif.ReqSigned = 1'b0;
    bif.ReqAddr   = 8'h12;
    bif.ReqWData  = 32'h0;
    #1;
    n_vec++;
    if (bif.ReqReady !== 1'b0) begin
      n_err++; $display("FAIL b2b_hs_ready: got %b required 0", bif.ReqReady);
    end
    @(posedge Clk);
    #1;
    bif.RspReady = 1'b0;
    n_vec++;
    if ({bif.RspValid, bif.ReqReady} !== 2'b01) begin
      n_err++;
      $display("FAIL b2b_after_hs: valid/ready got %b/%b required 0/1", bif.RspValid,
               bif.ReqReady);
    end
    model(1'b0, 2'b01, 1'b0, 8'h12, 32'h0, r);
    exp_q.push_back(r);
    @(posedge Clk);
    #1;
    bif.ReqValid = 1'b0;
    collect(rd, er, lat);
    e = exp_q.pop_front();
    n_vec++;
    if (rd !== e.rdata || rd !== 32'h0000_A1B2 || er !== 1'b0 || lat !== 2) begin
      n_err++;
      $display("FAIL b2b_second: got %h/%b lat %0d required 0000a1b2/0 lat 2", rd, er, lat);
    end
  endtask

  task automatic test_reset_mid_access();
    int w0, seen;
    w0 = wr_cycles;
    issue(1'b1, 2'b10, 1'b0, 8'h20, 32'h1122_3344, 1'b0);
    @(posedge Clk);
    @(posedge Clk);
    #1;
    n_vec++;
    if ({bif.MemWrite, bif.MemAddr} !== {1'b1, 8'h22}) begin
      n_err++;
      $display("FAIL rst_pre: write/addr got %b/%h required 1/22", bif.MemWrite, bif.MemAddr);
    end
    Rst = 1'b1;
    #1;
    n_vec++;
    if ({bif.MemWrite, bif.MemRead, bif.RspValid} !== 3'b000 || dut.state_q !== StIdle) begin
      n_err++;
      $display("FAIL rst_drop: w/r/v got %b%b%b state %0d required 000 state 0",
               bif.MemWrite, bif.MemRead, bif.RspValid, dut.state_q);
    end
    n_vec++;
    if (wr_cycles - w0 !== 2) begin
      n_err++; $display("FAIL rst_beats: got %0d required 2", wr_cycles - w0);
    end
    ref_mem[8'h20] = 8'h44;
    ref_mem[8'h21] = 8'h33;
    @(negedge Clk);
    @(negedge Clk);
    Rst = 1'b0;
    bif.RspReady = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clk);
      if (bif.RspValid) seen++;
    end
    bif.RspReady = 1'b0;
    n_vec++;
    if (seen != 0) begin
      n_err++; $display("FAIL rst_no_rsp: got %0d valid cycles required 0", seen);
    end
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (sim_mem[8'h20 + i] !== ref_mem[8'h20 + i]) begin
        n_err++;
        $display("FAIL rst_mem%0d: got %h required %h", i, sim_mem[8'h20 + i],
                 ref_mem[8'h20 + i]);
      end
    end
    n_vec++;
    if (both_hi != 0) begin
      n_err++; $display("FAIL strobe_overlap: got %0d cycles required 0", both_hi);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = init_byte(i);
    bif.ReqValid  = 1'b0;
    bif.ReqWrite  = 1'b0;
    bif.ReqSize   = 2'b00;
    bif.ReqSigned = 1'b0;
    bif.ReqAddr   = 8'h00;
    bif.ReqWData  = 32'h0;
    bif.RspReady  = 1'b0;
    test_reset();
    test_word_store();
    test_word_load();
    test_byte_half_load();
    test_misaligned();
    test_back_to_back();
    test_reset_mid_access();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
